// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction memory port between program loader (LOAD) and fetch (RUN).
// Define IMEM_ARB_RR_EN for round-robin RUN-state contention; otherwise fetch has fixed priority.
module imem_port_arbiter #(
   parameter int DEPTH = 32,
   parameter int AW    = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fetch_valid_i,
   input  logic [AW-1:0]            fetch_addr_i,
   output logic                     fetch_ready_o,
   output logic                     fetch_rvalid_o,
   output logic [31:0]              fetch_rdata_o,
   output logic                     fetch_err_o,
   input  logic                     load_valid_i,
   input  logic [AW-1:0]            load_addr_i,
   input  logic [31:0]              load_data_i,
   output logic                     load_ready_o,
   input  logic                     load_done_i,
   input  logic                     restart_i,
   output logic                     run_o,
   output logic [$clog2(DEPTH):0]   load_count_o,
   output logic [AW-1:0]            mem_addr_o,
   output logic                     mem_we_o,
   output logic [31:0]              mem_wdata_o,
   input  logic [31:0]              mem_rdata_i
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   typedef enum logic {LOAD, RUN} state_e;
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rvalid_q, err_q;
   logic [31:0]     rdata_q;
   logic            fetch_gnt, load_gnt, fetch_wins, fetch_err, load_in_range;
   assign fetch_err     = (|fetch_addr_i[1:0]) | (|fetch_addr_i[AW-1:IW+2]);
   assign load_in_range = ~|load_addr_i[AW-1:IW+2];
`ifdef IMEM_ARB_RR_EN
   logic rr_q;
   // remember who won the last contended cycle (1 = loader) so the other side wins next
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         rr_q <= 1'b0;
      else if (state_q == RUN && fetch_valid_i && load_valid_i)
         rr_q <= load_gnt;
   end
   assign fetch_wins = rr_q;
`else
   assign fetch_wins = 1'b1;
`endif
   // next state, load counter, grants and memory port mux
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      fetch_gnt   = 1'b0;
      load_gnt    = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      if (state_q == LOAD) begin
         load_gnt = load_valid_i;
         if (load_gnt && cnt_q != CW'(DEPTH))
            cnt_d = cnt_q + 1'b1;
         if (load_done_i || cnt_d == CW'(DEPTH))
            state_d = RUN;
      end else begin
         fetch_gnt = fetch_valid_i & (~load_valid_i | fetch_wins);
         load_gnt  = load_valid_i & ~fetch_gnt;
         if (restart_i) begin
            state_d = LOAD;
            cnt_d   = '0;
         end
      end
      if (fetch_gnt) begin
         mem_addr_o = fetch_addr_i;
      end else if (load_gnt) begin
         mem_addr_o  = {load_addr_i[AW-1:2], 2'b00};
         mem_we_o    = load_in_range;
         mem_wdata_o = load_data_i;
      end
   end
   assign fetch_ready_o  = fetch_gnt;
   assign load_ready_o   = (state_q == LOAD) | load_gnt;
   assign run_o          = (state_q == RUN);
   assign load_count_o   = cnt_q;
   assign fetch_rvalid_o = rvalid_q;
   assign fetch_rdata_o  = rdata_q;
   assign fetch_err_o    = err_q;
   // state, counter and one-cycle fetch response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= LOAD;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= fetch_gnt;
         if (fetch_gnt) begin
            err_q   <= fetch_err;
            rdata_q <= fetch_err ? '0 : mem_rdata_i;
         end
      end
   end
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed checks of load sequencing, fetch responses and RUN-state arbitration.
module tb_imem_port_arbiter;
   logic        clk = 0, rst = 1;
   logic        fetch_valid = 0, load_valid = 0, load_done = 0, restart = 0;
   logic [31:0] fetch_addr = 0, load_addr = 0, load_data = 0;
   logic        fetch_ready, fetch_rvalid, fetch_err, load_ready, run, mem_we;
   logic [31:0] fetch_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [5:0]  load_count;
   logic [31:0] mem [32];
   int          n_chk = 0, n_pass = 0;
   logic [4:0]  fw;

   imem_port_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .fetch_valid_i(fetch_valid), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
      .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata), .fetch_err_o(fetch_err),
      .load_valid_i(load_valid), .load_addr_i(load_addr), .load_data_i(load_data),
      .load_ready_o(load_ready), .load_done_i(load_done), .restart_i(restart),
      .run_o(run), .load_count_o(load_count),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr[6:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      fetch_valid = 1;
      #2;
      check("rst_run", run, 0);
      check("rst_cnt", load_count, 0);
      check("rst_rvalid", fetch_rvalid, 0);
      check("rst_rdata", fetch_rdata, 0);
      check("rst_err", fetch_err, 0);
      check("rst_load_ready", load_ready, 1);
      check("rst_fetch_ready", fetch_ready, 0);
      cyc;
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         load_valid = 1; load_addr = 4 * i; load_data = 32'h20010005 + i;
         #3;
         check("ld4_fetch_ready", fetch_ready, 0);
         check("ld4_we", mem_we, 1);
         check("ld4_addr", mem_addr, 4 * i);
         check("ld4_wdata", mem_wdata, 32'h20010005 + i);
         cyc;
      end
      load_valid = 0; fetch_valid = 0; load_done = 1;
      #3;
      check("ld4_cnt", load_count, 4);
      check("ld4_run_pre", run, 0);
      cyc;
      load_done = 0;
      #3;
      check("ld4_run", run, 1);
      check("idle_addr", mem_addr, 0);
      check("idle_we", mem_we, 0);
      fetch_valid = 1; fetch_addr = 8;
      #1;
      check("f8_ready", fetch_ready, 1);
      check("f8_addr", mem_addr, 8);
      check("f8_we", mem_we, 0);
      cyc;
      fetch_valid = 0;
      #3;
      check("f8_rvalid", fetch_rvalid, 1);
      check("f8_rdata", fetch_rdata, 32'h20010007);
      check("f8_err", fetch_err, 0);
      cyc;
      fetch_valid = 1; fetch_addr = 6;
      #3;
      check("f8_rvalid_drop", fetch_rvalid, 0);
      cyc;
      fetch_addr = 128;
      #3;
      check("f6_rvalid", fetch_rvalid, 1);
      check("f6_err", fetch_err, 1);
      check("f6_rdata", fetch_rdata, 0);
      cyc;
      fetch_valid = 0;
      #3;
      check("f128_rvalid", fetch_rvalid, 1);
      check("f128_err", fetch_err, 1);
      check("f128_rdata", fetch_rdata, 0);
      load_valid = 1; load_addr = 8; load_data = 32'hDEADBEEF;
      #1;
      check("rl_ready", load_ready, 1);
      check("rl_we", mem_we, 1);
      check("rl_addr", mem_addr, 8);
      cyc;
      load_addr = 128; load_data = 32'h55;
      #3;
      check("rl_cnt", load_count, 4);
      check("rl_oor_ready", load_ready, 1);
      check("rl_oor_we", mem_we, 0);
      cyc;
      load_valid = 0; fetch_valid = 1; fetch_addr = 8;
      cyc;
      fetch_valid = 0;
      #3;
      check("patch_rdata", fetch_rdata, 32'hDEADBEEF);
      check("oor_cnt", load_count, 4);
`ifdef IMEM_ARB_RR_EN
      fw = 5'b01010;
`else
      fw = 5'b11111;
`endif
      fetch_valid = 1; fetch_addr = 4; load_valid = 1; load_addr = 12; load_data = 32'h11111111;
      for (int k = 0; k < 5; k++) begin
         #3;
         check("arb_fetch_ready", fetch_ready, fw[k]);
         check("arb_load_ready", load_ready, !fw[k]);
         check("arb_we", mem_we, !fw[k]);
         cyc;
      end
      load_valid = 0; fetch_addr = 0; restart = 1;
      #3;
      check("rs_fetch_ready", fetch_ready, 1);
      cyc;
      restart = 0; fetch_valid = 0;
      #3;
      check("rs_rvalid", fetch_rvalid, 1);
      check("rs_rdata", fetch_rdata, 32'h20010005);
      check("rs_run", run, 0);
      check("rs_cnt", load_count, 0);
      for (int i = 0; i < 32; i++) begin
         load_valid = 1; load_addr = 4 * i; load_data = 32'hA0000000 + i;
         #3;
         if (i == 31) begin
            check("ld32_cnt_pre", load_count, 31);
            check("ld32_run_pre", run, 0);
         end
         cyc;
      end
      load_valid = 0;
      #3;
      check("ld32_run", run, 1);
      check("ld32_cnt", load_count, 32);
      fetch_valid = 1; fetch_addr = 124;
      cyc;
      fetch_addr = 4;
      #3;
      check("f124_rdata", fetch_rdata, 32'hA000001F);
      check("f124_err", fetch_err, 0);
      cyc;
      fetch_valid = 0;
      #1;
      check("rstp_rvalid_pre", fetch_rvalid, 1);
      rst = 1;
      #1;
      check("rstp_rvalid", fetch_rvalid, 0);
      check("rstp_rdata", fetch_rdata, 0);
      check("rstp_run", run, 0);
      check("rstp_cnt", load_count, 0);
      cyc;
      rst = 0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1; load_addr = 4 * i; load_data = i;
         cyc;
      end
      load_valid = 0;
      #1;
      check("midld_cnt_pre", load_count, 2);
      rst = 1;
      #1;
      check("midld_cnt", load_count, 0);
      cyc;
      rst = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
